// File: rtl/sd_clk_pkg.sv
// rtl/sd_clk_pkg.sv - shared state type and divisor constants for the SD clock generator
package sd_clk_pkg;

  typedef enum logic [1:0] {
    LO   = 2'd0,
    HI   = 2'd1,
    STOP = 2'd2
  } sd_clk_state_e;

  localparam int SD_DIV_W    = 8;
  localparam int SD_DIV_400K = 33;
  // 27 MHz / 2 = 13.5 MHz: the fastest ratio, nearest achievable to 25 MHz
  localparam int SD_DIV_25M  = 0;

endpackage

// File: rtl/sd_clk_div_cnt.sv
// rtl/sd_clk_div_cnt.sv - phase counter with terminal-count compare against lim
module sd_clk_div_cnt
  import sd_clk_pkg::*;
#(
  parameter int W = SD_DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic         tc
);

  logic [W-1:0] cnt;

  assign tc = (cnt == lim);

  // Clearing on tc keeps cnt <= lim, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_clk_gen.sv
// rtl/sd_clk_gen.sv - glitch-free programmable SD clock generator; SD_CLK_GEN_STOP_EN adds clock parking
module sd_clk_gen
  import sd_clk_pkg::*;
#(
  parameter int DIV_W     = SD_DIV_W,
  parameter int DIV_RESET = SD_DIV_400K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic [DIV_W-1:0] div_cur,
  input  logic             en,
  output logic             sd_clk,
  output logic             sd_rise,
  output logic             sd_fall,
  output logic             stopped
);

`ifdef SD_CLK_GEN_STOP_EN
  localparam sd_clk_state_e RST_STATE = STOP;
`else
  localparam sd_clk_state_e RST_STATE = LO;
`endif

  sd_clk_state_e    state;
  sd_clk_state_e    state_nx;
  logic             tc;
  logic             clr;
  logic             apply;
  logic             rise_nx;
  logic             fall_nx;
  logic [DIV_W-1:0] pend;
  logic             pend_v;

  sd_clk_div_cnt #(
    .W(DIV_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .lim (div_cur),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    apply    = 1'b0;
    unique case (state)
      LO: begin
`ifdef SD_CLK_GEN_STOP_EN
        // Dropping en in a low phase parks at once; sd_clk is already low.
        if (!en) begin
          state_nx = STOP;
          clr      = 1'b1;
        end else if (tc) begin
          state_nx = HI;
        end
`else
        if (tc) state_nx = HI;
`endif
      end
      HI: begin
        if (tc) state_nx = LO;
`ifdef SD_CLK_GEN_STOP_EN
        if (tc && !en) state_nx = STOP;
`endif
      end
      default: begin
        clr = 1'b1;
`ifdef SD_CLK_GEN_STOP_EN
        state_nx = en ? LO : STOP;
`else
        state_nx = LO;
`endif
      end
    endcase
    rise_nx = (state == LO) && (state_nx == HI);
    fall_nx = (state == HI) && (state_nx != HI);
    // Divisor changes only at the end of a high phase, so no phase is ever cut short.
    apply   = pend_v && (fall_nx || (state == STOP));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_clk  <= 1'b0;
      sd_rise <= 1'b0;
      sd_fall <= 1'b0;
      div_ack <= 1'b0;
      div_cur <= DIV_W'(DIV_RESET);
      pend    <= '0;
      pend_v  <= 1'b0;
    end else begin
      sd_clk  <= (state_nx == HI);
      sd_rise <= rise_nx;
      sd_fall <= fall_nx;
      div_ack <= apply;
      if (apply) div_cur <= pend;
      if (div_load) begin
        pend   <= div_in;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

`ifdef SD_CLK_GEN_STOP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stopped <= 1'b1;
    end else begin
      stopped <= (state_nx == STOP);
    end
  end
`else
  logic unused_en;
  assign unused_en = en;
  assign stopped   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb/tb_sd_clk_gen.sv - directed self-checking bench for sd_clk_gen
`timescale 1ns/1ps
module tb_sd_clk_gen;

`ifdef SD_CLK_GEN_STOP_EN
  localparam int   FIRST_RISE  = 35;
  localparam logic RST_STOPPED = 1'b1;
`else
  localparam int   FIRST_RISE  = 34;
  localparam logic RST_STOPPED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic [7:0] div_cur;
  logic       en;
  logic       sd_clk;
  logic       sd_rise;
  logic       sd_fall;
  logic       stopped;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  sd_clk_gen #(
    .DIV_W     (8),
    .DIV_RESET (33)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_cur  (div_cur),
    .en       (en),
    .sd_clk   (sd_clk),
    .sd_rise  (sd_rise),
    .sd_fall  (sd_fall),
    .stopped  (stopped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (div_ack === 1'b1) ack_cnt++;
  endtask

  task automatic wait_rise(input int budget, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < budget) begin
      step();
      i++;
      if (sd_rise === 1'b1) n = i;
    end
  endtask

  task automatic wait_fall(input int budget, output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < budget) begin
      step();
      i++;
      if (sd_fall === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; en = 1'b1; div_load = 1'b0; div_in = 8'd0;
    repeat (3) step();
    checks++;
    if ({sd_clk, sd_rise, sd_fall, div_ack} !== 4'b0000) begin
      failures++; $display("FAIL reset_outputs: got %b expected 0000", {sd_clk, sd_rise, sd_fall, div_ack});
    end
    checks++;
    if (div_cur !== 8'd33) begin
      failures++; $display("FAIL reset_div_cur: got %0d expected 33", div_cur);
    end
    checks++;
    if (stopped !== RST_STOPPED) begin
      failures++; $display("FAIL reset_stopped: got %b expected %b", stopped, RST_STOPPED);
    end
    rst = 1'b0;
    wait_rise(200, n);
    checks++;
    if (n !== FIRST_RISE) begin
      failures++; $display("FAIL first_rise: got %0d expected %0d", n, FIRST_RISE);
    end
    checks++;
    if (sd_clk !== 1'b1) begin
      failures++; $display("FAIL rise_coincident: got sd_clk=%b expected 1", sd_clk);
    end
    step();
    checks++;
    if ({sd_clk, sd_rise} !== 2'b10) begin
      failures++; $display("FAIL rise_single_cycle: got %b expected 10", {sd_clk, sd_rise});
    end
    wait_fall(200, n);
    checks++;
    if (n !== 33) begin
      failures++; $display("FAIL rise_to_fall: got %0d expected 33", n);
    end
    wait_rise(200, n);
    checks++;
    if (n !== 34) begin
      failures++; $display("FAIL fall_to_rise: got %0d expected 34", n);
    end
  endtask

  task automatic test_ratio_switch();
    int n;
    int a0;
    a0 = ack_cnt;
    wait_fall(200, n);
    checks++;
    if (n !== 34) begin
      failures++; $display("FAIL switch_high_before: got %0d expected 34", n);
    end
    repeat (10) step();
    div_load = 1'b1; div_in = 8'd0;
    step();
    div_load = 1'b0;
    wait_rise(200, n);
    checks++;
    if (n !== 23) begin
      failures++; $display("FAIL switch_low_kept: got %0d expected 23", n);
    end
    checks++;
    if (ack_cnt !== a0) begin
      failures++; $display("FAIL switch_early_ack: got %0d expected %0d", ack_cnt, a0);
    end
    wait_fall(200, n);
    checks++;
    if (n !== 34) begin
      failures++; $display("FAIL switch_high_kept: got %0d expected 34", n);
    end
    checks++;
    if ({div_ack, div_cur} !== {1'b1, 8'd0}) begin
      failures++; $display("FAIL switch_ack_on_fall: got ack=%b cur=%0d expected ack=1 cur=0", div_ack, div_cur);
    end
    step();
    checks++;
    if ({sd_clk, sd_rise} !== 2'b11) begin
      failures++; $display("FAIL switch_fast_rise: got %b expected 11", {sd_clk, sd_rise});
    end
    step();
    checks++;
    if ({sd_clk, sd_fall} !== 2'b01) begin
      failures++; $display("FAIL switch_fast_fall: got %b expected 01", {sd_clk, sd_fall});
    end
    step();
    checks++;
    if ({sd_clk, sd_rise, ack_cnt - a0} !== {2'b11, 32'd1}) begin
      failures++; $display("FAIL switch_toggle_acks: got clk=%b rise=%b acks=%0d expected 1 1 1", sd_clk, sd_rise, ack_cnt - a0);
    end
  endtask

  task automatic test_mid_reset();
    int a0;
    div_load = 1'b1; div_in = 8'd9;
    step();
    div_load = 1'b0;
    step();
    checks++;
    if (sd_clk !== 1'b1) begin
      failures++; $display("FAIL midrst_in_high: got %b expected 1", sd_clk);
    end
    a0 = ack_cnt;
    rst = 1'b1;
    step();
    checks++;
    if ({sd_clk, div_ack, div_cur} !== {2'b00, 8'd33}) begin
      failures++; $display("FAIL midrst_state: got clk=%b ack=%b cur=%0d expected 0 0 33", sd_clk, div_ack, div_cur);
    end
    rst = 1'b0;
    repeat (80) step();
    checks++;
    if (ack_cnt !== a0 || div_cur !== 8'd33) begin
      failures++; $display("FAIL midrst_discard: got acks=%0d cur=%0d expected acks=%0d cur=33", ack_cnt, div_cur, a0);
    end
  endtask

  task automatic test_overwrite();
    int n;
    int a0;
    wait_rise(200, n);
    wait_fall(200, n);
    checks++;
    if (n !== 34) begin
      failures++; $display("FAIL ovr_sync: got %0d expected 34", n);
    end
    a0 = ack_cnt;
    repeat (5) step();
    div_load = 1'b1; div_in = 8'd5;
    step();
    div_load = 1'b0;
    repeat (3) step();
    div_load = 1'b1; div_in = 8'd2;
    step();
    div_load = 1'b0;
    wait_rise(200, n);
    checks++;
    if (n !== 24) begin
      failures++; $display("FAIL ovr_low_kept: got %0d expected 24", n);
    end
    wait_fall(200, n);
    checks++;
    if ({div_ack, div_cur} !== {1'b1, 8'd2}) begin
      failures++; $display("FAIL ovr_latest_wins: got ack=%b cur=%0d expected ack=1 cur=2", div_ack, div_cur);
    end
    wait_rise(200, n);
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL ovr_low_half: got %0d expected 3", n);
    end
    wait_fall(200, n);
    checks++;
    if (n !== 3 || ack_cnt - a0 !== 1) begin
      failures++; $display("FAIL ovr_high_half: got half=%0d acks=%0d expected half=3 acks=1", n, ack_cnt - a0);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int a0;
    a0 = ack_cnt;
    wait_rise(200, n);
    div_load = 1'b1; div_in = 8'd2;
    step();
    div_load = 1'b0;
    step();
    div_load = 1'b1; div_in = 8'd7;
    step();
    div_load = 1'b0;
    checks++;
    if ({sd_fall, div_ack, div_cur} !== {2'b11, 8'd2}) begin
      failures++; $display("FAIL b2b_first_ack: got fall=%b ack=%b cur=%0d expected 1 1 2", sd_fall, div_ack, div_cur);
    end
    repeat (5) step();
    checks++;
    if (ack_cnt - a0 !== 1) begin
      failures++; $display("FAIL b2b_no_merge: got acks=%0d expected 1", ack_cnt - a0);
    end
    step();
    checks++;
    if ({sd_fall, div_ack, div_cur} !== {2'b11, 8'd7}) begin
      failures++; $display("FAIL b2b_second_ack: got fall=%b ack=%b cur=%0d expected 1 1 7", sd_fall, div_ack, div_cur);
    end
    wait_rise(200, n);
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL b2b_new_half: got %0d expected 8", n);
    end
  endtask

`ifdef SD_CLK_GEN_STOP_EN
  task automatic test_stop_start();
    int n;
    int i;
    div_load = 1'b1; div_in = 8'd9;
    step();
    div_load = 1'b0;
    i = 0;
    while (div_ack !== 1'b1 && i < 50) begin
      step();
      i++;
    end
    checks++;
    if (div_cur !== 8'd9) begin
      failures++; $display("FAIL stop_setup: got cur=%0d expected 9", div_cur);
    end
    wait_rise(200, n);
    checks++;
    if (n !== 10) begin
      failures++; $display("FAIL stop_low_half: got %0d expected 10", n);
    end
    repeat (2) step();
    en = 1'b0;
    wait_fall(200, n);
    checks++;
    if (n !== 8) begin
      failures++; $display("FAIL stop_high_full: got %0d expected 8", n);
    end
    checks++;
    if ({stopped, sd_clk} !== 2'b10) begin
      failures++; $display("FAIL stop_on_fall: got stopped=%b clk=%b expected 1 0", stopped, sd_clk);
    end
    repeat (5) step();
    checks++;
    if ({stopped, sd_clk, sd_rise} !== 3'b100) begin
      failures++; $display("FAIL stop_parked: got %b expected 100", {stopped, sd_clk, sd_rise});
    end
    en = 1'b1;
    wait_rise(200, n);
    checks++;
    if (n !== 11 || stopped !== 1'b0) begin
      failures++; $display("FAIL stop_restart: got delay=%0d stopped=%b expected 11 0", n, stopped);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ratio_switch();
    test_mid_reset();
    test_overwrite();
    test_back_to_back();
`ifdef SD_CLK_GEN_STOP_EN
    test_stop_start();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_clk_gen.md
# sd_clk_gen

Programmable, glitch-free SD-card clock generator replacing fixed-ratio primitive dividers. Produces the registered SD clock level plus single-cycle rise/fall strobes for the command/data engines, all in the system clock domain. Runtime ratio changes, such as 400 kHz identification to 25 MHz transfer, take effect only at a low-phase boundary. An optional stop request parks the SD clock low.

## Interface
- `DIV_W`, 8: divisor width.
- `DIV_RESET`, 33: divisor after reset; 27 MHz / 68 ≈ 397 kHz.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `div_in` in DIV_W: requested divisor `d`. Half-period is d+1 `clk` cycles; full period is 2·(d+1).
- `div_load` in 1: single-cycle request to capture `div_in`.
- `div_ack` out 1: single-cycle pulse in the cycle the new divisor becomes active.
- `div_cur` out DIV_W: divisor currently in use.
- `en` in 1: run request; see Configuration.
- `sd_clk` out 1: registered SD clock level.
- `sd_rise` out 1: high for one cycle, in the cycle `sd_clk` first reads 1.
- `sd_fall` out 1: high for one cycle, in the cycle `sd_clk` first reads 0.
- `stopped` out 1: the clock is parked low.

## Operation
- States:
  - `LO`: counting the low phase.
  - `HI`: counting the high phase.
  - `STOP`: parked; present only with the macro.
- Counter `cnt` is DIV_W bits.
  - Increments every cycle in `LO`/`HI`.
  - At `cnt == div_cur`, the state toggles and `cnt` is set to 0.
  - `cnt` never exceeds `div_cur`, so there is no wrap.
- `LO→HI` at terminal count: `sd_clk` becomes 1 and `sd_rise` pulses.
- `HI→LO` at terminal count: `sd_clk` becomes 0 and `sd_fall` pulses.
- Divisor update:
  - `div_load` captures `div_in` into `pend` and sets `pend_v`.
  - A `div_load` while `pend_v` is set overwrites `pend`; latest wins, single ack.
  - `pend` is applied (`div_cur <= pend`, `pend_v <= 0`, `div_ack` pulses) on the `HI→LO` transition cycle, or on the next cycle if in `STOP`.
  - A new divisor therefore never shortens or stretches a high phase.
  - A `div_load` in the same cycle as an apply is captured as a new pending request, not merged.
- `d = 0` is legal: `clk`/2, and `sd_rise`/`sd_fall` alternate every cycle.
- Reset:
  - `sd_clk`, `sd_rise`, `sd_fall`, `div_ack`, `pend_v` = 0.
  - `cnt` = 0; state `LO`.
  - `div_cur` = DIV_RESET.
  - `stopped` = 0 without the macro; = 1 with it (state `STOP`, since `en` is sampled from reset).
- A reset mid-phase or with an update pending discards `pend` with no ack.

## Timing
- Outputs are registered. Strobes are coincident with the `sd_clk` edge they mark, never a cycle late.
- After reset release, with `en = 1`, the first `sd_rise` occurs at cycle `div_cur + 1`, counting the first post-reset edge as cycle 1.
- `div_ack` latency runs from `div_load` to the end of the current high phase, or to the following one if currently low: at most 2·(d_old+1)+1 cycles.
- The first low phase after an apply already uses the new divisor.

## Configuration
- Macro: `SD_CLK_GEN_STOP_EN`.
- **Defined:** clock stopping is available.
  - `en = 0` lets the current high phase complete. At the `HI→LO` boundary, or immediately if in `LO`, the state moves to `STOP`: `sd_clk` = 0, `stopped` = 1, `cnt` = 0.
  - `en = 1` in `STOP` moves to `LO` with `cnt` = 0 on the next cycle, and clears `stopped`. The first `sd_rise` follows d+1 cycles later.
  - `en` toggling within one low phase never produces a runt pulse.
- **Undefined:**
  - `en` is ignored and the clock free-runs.
  - `stopped` is tied to 0.
  - The `STOP` state and its logic are absent.

## Structure
- Package `sd_clk_pkg`:
  - state enum `{LO, HI, STOP}`;
  - `SD_DIV_W` = 8;
  - `SD_DIV_400K` = 33;
  - `SD_DIV_25M` = 0, giving 13.5 MHz at 27 MHz, the nearest achievable.
- Sub-module `sd_clk_div_cnt`: the counter with terminal-count compare. It has inputs `clr` and `lim`, and outputs `tc`.
- The top holds the FSM, pending register, strobes and ack.

## Test plan
- **Reset default:** release `rst` with `en = 1` → first `sd_rise` at cycle 34; period 68, with `sd_rise`→`sd_fall` 34 cycles apart.
- **Ratio switch:** at d = 33, assert `div_load` with `div_in = 0` mid-low-phase. Required response:
  - the current low and next high phase each stay 34 cycles;
  - `div_ack` pulses on the fall cycle;
  - `sd_clk` then toggles every cycle.
- **Overwrite:** `div_load` with 5, then with 2, within one phase → exactly one `div_ack`; `div_cur` = 2; half-period 3.
- **Simultaneous load and apply:** `div_load` with 7 in the apply cycle of a pending 2 → ack for 2, then a second ack for 7 one period later.
- **Stop/start** (macro defined): drop `en` 3 cycles into a high phase of d = 9. Required response:
  - high lasts the full 10 cycles;
  - `stopped` = 1 on the fall cycle;
  - raising `en` gives the first `sd_rise` 11 cycles later.
- **Mid-operation reset:** assert `rst` with `pend_v` = 1 during `HI` → `sd_clk` = 0, no `div_ack`, `div_cur` = 33 the next cycle.
